vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Timing front end for the VGA output path; sits directly upstream of the colour/output stage (vgacontroller).
- Divides the 100 MHz system clock to a 25 MHz pixel tick.
- Runs horizontal and vertical phase FSMs for 640x480@60 Hz and produces registered hsync/vsync, display-enable and pixel coordinates.
- The colour stage uses these outputs to choose VGA_RED/GREEN/BLUE and forwards the syncs to the pins.

Parameters:
- CLK_DIV, 4, system clocks per pixel tick (>=2)
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run when high; when low, timing is held at origin
- pixel_tick  out  1  one-clk strobe, once per CLK_DIV clks
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- display_on  out  1  high while (pixel_x, pixel_y) is in the visible area
- pixel_x  out  10  horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  vertical count, 0..V_TOTAL-1
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0)

Behaviour:
- Derived totals:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (800 by default)
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (525 by default)
- Reset (reset=0, async):
  - prescaler = 0, h/v counts = 0, both FSMs in ACTIVE
  - hsync = 1, vsync = 1, display_on = 1 (origin is visible)
  - pixel_tick = 0, frame_start = 0, pixel_x = 0, pixel_y = 0
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - pixel_tick is registered high for exactly the clk in which prescaler == CLK_DIV-1.
- Horizontal FSM, advanced only on pixel_tick:
  - States H_ACT, H_FP, H_SY, H_BP.
  - h_count increments per tick. Transitions at h_count = H_VISIBLE, +H_FRONT, +H_SYNC, and at H_TOTAL-1 (-> H_ACT, h_count = 0).
- Vertical FSM, advanced only on a tick where h_count == H_TOTAL-1:
  - States V_ACT, V_FP, V_SY, V_BP.
  - Boundaries are analogous; v_count wraps to 0 after V_TOTAL-1.
- Outputs are registered and update on the same edge as the counters, computed from next-state values, so there is zero skew between coordinates and flags:
  - hsync = 0 iff next H state is H_SY (pixels 656..751 by default)
  - vsync = 0 iff next V state is V_SY (lines 490..491 by default)
  - display_on = (next H == H_ACT) && (next V == V_ACT)
  - pixel_x / pixel_y = next h_count / v_count
- frame_start: high for one clk on the tick where (h,v) = (H_TOTAL-1, V_TOTAL-1) wraps to (0,0). It coincides with that pixel_tick.
- enable low (synchronous):
  - Next edge forces prescaler, counters, FSMs and outputs to their reset values. No ticks are generated.
  - On re-enable, the first pixel_tick occurs CLK_DIV clks later.
- Reset asserted mid-line/mid-frame: immediate return to reset values. No partial sync pulse is held.
- All counter comparisons are unsigned and width-safe; counts never exceed H_TOTAL-1 / V_TOTAL-1.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN
- Defined:
  - Adds output port frame_count [7:0].
  - Reset value 0, cleared when enable is low.
  - Increments by 1 on each frame_start; wraps 255 -> 0.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset low for 100 ns, then high with enable=1:
  - All outputs hold reset values during reset.
  - First pixel_tick arrives 4 clks after release; ticks then repeat every 4 clks (40 ns).
- Horizontal timing:
  - hsync falls at pixel_x = 656, rises at pixel_x = 752.
  - Low for 96 ticks = 384 clks; line period is 3200 clks (32 us).
  - display_on falls at pixel_x = 640.
- Vertical timing:
  - vsync is low exactly for pixel_y = 490..491, i.e. 6400 clks.
  - Frame period is 1,680,000 clks.
  - frame_start pulses once per frame, with pixel_x = pixel_y = 0 on that clk.
- Reset pulse at pixel_x = 700, pixel_y = 491 (inside both syncs):
  - hsync = vsync = 1 and counters = 0 immediately, without waiting for a clk edge.
  - Timing restarts cleanly after release.
- Drop enable for 50 clks mid-line:
  - Outputs go to reset values and no pixel_tick occurs while low.
  - After re-enable, the first tick comes 4 clks later and the h count restarts at 0.
- With VGA_FRAME_COUNT_EN defined, run 257 frames (simulation-scaled parameters allowed):
  - frame_count sequence is 0, 1, ..., 255, 0, 1.

Source files
------------

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 timing front end for the VGA colour stage.
// Divides the system clock down to a pixel tick and runs horizontal and
// vertical phase FSMs. Sync, display-enable and coordinate outputs are all
// registered from next-state values, so flags and coordinates change together.
// Optional build macro VGA_FRAME_COUNT_EN adds an 8-bit frame counter output.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  , output logic [7:0] frame_count
`endif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  // Count values at which each phase begins.
  localparam logic [9:0] H_FP_START = 10'(H_VISIBLE);
  localparam logic [9:0] H_SY_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_BP_START = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_FP_START = 10'(V_VISIBLE);
  localparam logic [9:0] V_SY_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_BP_START = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} h_state_e;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_e;

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  h_state_e      h_state_q, h_state_d;
  v_state_e      v_state_q, v_state_d;
  logic [9:0]    h_cnt_q, h_cnt_d;
  logic [9:0]    v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          disp_q, disp_d;
  logic          fs_q, fs_d;
  logic          line_end;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0]    fc_q, fc_d;
`endif

  // Prescaler: the tick is asserted in the clk where the prescaler sits at its last value.
  always_comb begin
    pre_d  = '0;
    tick_d = 1'b0;
    if (enable) begin
      pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
      tick_d = (pre_d == PRE_LAST);
    end
  end

  // Horizontal phase FSM and pixel counter, stepped once per tick.
  always_comb begin
    h_state_d = h_state_q;
    h_cnt_d   = h_cnt_q;
    line_end  = tick_d && (h_cnt_q == H_LAST);
    if (!enable) begin
      h_state_d = H_ACT;
      h_cnt_d   = '0;
    end else if (tick_d) begin
      h_cnt_d = line_end ? '0 : h_cnt_q + 10'd1;
      case (h_state_q)
        H_ACT:   if (h_cnt_d == H_FP_START) h_state_d = H_FP;
        H_FP:    if (h_cnt_d == H_SY_START) h_state_d = H_SY;
        H_SY:    if (h_cnt_d == H_BP_START) h_state_d = H_BP;
        H_BP:    if (line_end)              h_state_d = H_ACT;
        default: h_state_d = H_ACT;
      endcase
    end
  end

  // Vertical phase FSM and line counter, stepped at the end of each line.
  always_comb begin
    v_state_d = v_state_q;
    v_cnt_d   = v_cnt_q;
    if (!enable) begin
      v_state_d = V_ACT;
      v_cnt_d   = '0;
    end else if (line_end) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      case (v_state_q)
        V_ACT:   if (v_cnt_d == V_FP_START) v_state_d = V_FP;
        V_FP:    if (v_cnt_d == V_SY_START) v_state_d = V_SY;
        V_SY:    if (v_cnt_d == V_BP_START) v_state_d = V_BP;
        V_BP:    if (v_cnt_q == V_LAST)     v_state_d = V_ACT;
        default: v_state_d = V_ACT;
      endcase
    end
  end

  // Output flags derived from next-state so they align with the coordinates.
  always_comb begin
    hsync_d = (h_state_d != H_SY);
    vsync_d = (v_state_d != V_SY);
    disp_d  = (h_state_d == H_ACT) && (v_state_d == V_ACT);
    fs_d    = line_end && (v_cnt_q == V_LAST);
`ifdef VGA_FRAME_COUNT_EN
    fc_d    = fc_q;
    if (!enable)   fc_d = '0;
    else if (fs_d) fc_d = fc_q + 8'd1;
`endif
  end

  // State and output registers; reset returns everything to the visible origin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q     <= '0;
      tick_q    <= 1'b0;
      h_state_q <= H_ACT;
      v_state_q <= V_ACT;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      disp_q    <= 1'b1;
      fs_q      <= 1'b0;
`ifdef VGA_FRAME_COUNT_EN
      fc_q      <= '0;
`endif
    end else begin
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      disp_q    <= disp_d;
      fs_q      <= fs_d;
`ifdef VGA_FRAME_COUNT_EN
      fc_q      <= fc_d;
`endif
    end
  end

  assign pixel_tick  = tick_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = disp_q;
  assign pixel_x     = h_cnt_q;
  assign pixel_y     = v_cnt_q;
  assign frame_start = fs_q;
`ifdef VGA_FRAME_COUNT_EN
  assign frame_count = fc_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: self-checking bench for vga_sync_gen with scaled timing.
// Scaled timing: 8 pixels/line (4 visible, 1 front, 2 sync, 1 back),
// 6 lines/frame (2 visible, 1 front, 2 sync, 1 back), 4 clks per pixel.
module tb_vga_sync_gen;

  localparam int D  = 4;
  localparam int HV = 4, HF = 1, HS = 2, HB = 1;
  localparam int VV = 2, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int LIM = 2000;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       pixel_tick, hsync, vsync, display_on, frame_start;
  logic [9:0] pixel_x, pixel_y;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count;
`endif

  int checks   = 0;
  int failures = 0;
  int r        = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  vga_sync_gen #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pixel_tick(pixel_tick), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // r = clocks run since the last reset/disable; everything follows from it.
  always @(posedge clk or negedge reset) begin
    if (!reset)       r <= 0;
    else if (!enable) r <= 0;
    else              r <= r + 1;
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected outputs after n running clocks, packed {tick,hs,vs,disp,fs,x,y}.
  function automatic int model_out(input int n);
    int ticks, p, x, y;
    bit tk, hs, vs, dp, fs;
    ticks = (n + 1) / D;
    p     = ticks % (HT * VT);
    x     = p % HT;
    y     = p / HT;
    tk    = ((n % D) == D - 1);
    fs    = tk && (p == 0);
    hs    = !(x >= HV + HF && x < HV + HF + HS);
    vs    = !(y >= VV + VF && y < VV + VF + VS);
    dp    = (x < HV) && (y < VV);
    return int'({tk, hs, vs, dp, fs, 10'(x), 10'(y)});
  endfunction

  function automatic int dut_out();
    return int'({pixel_tick, hsync, vsync, display_on, frame_start, pixel_x, pixel_y});
  endfunction

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_cycle", dut_out(), model_out(r));
`ifdef VGA_FRAME_COUNT_EN
      check("model_frame_count", int'(frame_count), (((r + 1) / D) / (HT * VT)) % 256);
`endif
    end
  end

  function automatic int cur(input int sel);
    case (sel)
      0:       return int'(pixel_tick);
      1:       return int'(hsync);
      2:       return int'(vsync);
      3:       return int'(display_on);
      4:       return int'(frame_start);
      5:       return int'(pixel_x);
      default: return int'(pixel_y);
    endcase
  endfunction

  task automatic wait_for(input string nm, input int sel, input int val, input int lim);
    int n;
    n = 0;
    while (cur(sel) != val && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cur(sel) != val) check({nm, "_timeout"}, cur(sel), val);
  endtask

  initial begin
    int c0, c1, n;
    reset  = 1'b0;
    enable = 1'b1;
    #2 chk_en = 1'b1;
    #48;
    check("reset_outputs", dut_out(), int'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0}));
    #51;
    reset = 1'b1;
    c0 = cyc;

    // tick shows in the 4th clk period after release (prescaler 0,1,2,3)
    wait_for("first_tick", 0, 1, LIM);
    check("first_tick_edges", cyc - c0, 3);
    check("first_tick_x", int'(pixel_x), 1);
    c0 = cyc;
    wait_for("tick_low", 0, 0, LIM);
    wait_for("tick2", 0, 1, LIM);
    check("tick_period", cyc - c0, 4);

    // horizontal timing
    wait_for("disp_fall", 3, 0, LIM);
    check("disp_fall_x", int'(pixel_x), HV);
    wait_for("hs_fall", 1, 0, LIM);
    check("hs_fall_x", int'(pixel_x), 5);
    c0 = cyc;
    wait_for("hs_rise", 1, 1, LIM);
    check("hs_rise_x", int'(pixel_x), 7);
    check("hs_low_clks", cyc - c0, 8);
    wait_for("hs_fall2", 1, 0, LIM);
    check("line_period", cyc - c0, 32);

    // vertical timing
    wait_for("vs_fall", 2, 0, LIM);
    check("vs_fall_y", int'(pixel_y), 3);
    check("vs_fall_x", int'(pixel_x), 0);
    c1 = cyc;
    wait_for("vs_rise", 2, 1, LIM);
    check("vs_rise_y", int'(pixel_y), 5);
    check("vs_low_clks", cyc - c1, 64);

    // frame start
    wait_for("fs", 4, 1, LIM);
    check("fs_xy", int'({pixel_x, pixel_y}), 0);
    c1 = cyc;
    wait_for("fs_low", 4, 0, LIM);
    check("fs_width", cyc - c1, 1);
    wait_for("fs2", 4, 1, LIM);
    check("frame_period", cyc - c1, 192);

    // async reset while inside both sync pulses
    wait_for("y4", 6, 4, LIM);
    wait_for("x6", 5, 6, LIM);
    check("in_syncs", int'({hsync, vsync}), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_reset", int'({hsync, vsync, pixel_x, pixel_y}), int'({1'b1, 1'b1, 20'd0}));
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    c0 = cyc;
    wait_for("post_reset_tick", 0, 1, LIM);
    check("post_reset_tick_edges", cyc - c0, 3);
    check("post_reset_x", int'(pixel_x), 1);

    // enable dropped mid-line for 50 clks
    wait_for("x3", 5, 3, LIM);
    @(negedge clk);
    #1 enable = 1'b0;
    n = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (pixel_tick) n++;
    end
    check("ticks_while_disabled", n, 0);
    check("disabled_outputs", dut_out(), int'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0}));
    @(negedge clk);
    #1 enable = 1'b1;
    c0 = cyc;
    wait_for("reenable_tick", 0, 1, LIM);
    check("reenable_tick_edges", cyc - c0, 3);
    check("reenable_x", int'(pixel_x), 1);

`ifdef VGA_FRAME_COUNT_EN
    check("fc_start", int'(frame_count), 0);
    for (int k = 1; k <= 257; k++) begin
      wait_for("fc_fs", 4, 1, 400);
      check("fc_seq", int'(frame_count), k % 256);
      wait_for("fc_fs_low", 4, 0, 400);
    end
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
